// File: rtl/calc_pkg.sv
// Shared encodings for the keyboard calculator: opcodes, register commands,
// sequencer FSM states and the opcode-to-command-word decode.
`timescale 1ns/1ps
package calc_pkg;

    localparam logic [2:0] OP_CLRLD = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_DISP  = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;

    localparam logic [1:0] TN_CLEAR = 2'b00;
    localparam logic [1:0] TN_LOAD  = 2'b01;
    localparam logic [1:0] TN_HOLD  = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    typedef struct packed {
        logic [1:0] tx;
        logic [1:0] ty;
        logic [1:0] tz;
    } cmd_word_t;

    localparam cmd_word_t CMD_IDLE = '{tx: TN_HOLD, ty: TN_HOLD, tz: TN_HOLD};

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_NOP;
    endfunction

    function automatic cmd_word_t op_cmd(input logic [2:0] op);
        cmd_word_t w;
        case (op)
            OP_CLRLD: w = '{tx: TN_CLEAR, ty: TN_CLEAR, tz: TN_CLEAR};
            OP_ADD,
            OP_SUB:   w = '{tx: TN_CLEAR, ty: TN_LOAD,  tz: TN_HOLD};
            OP_DISP:  w = '{tx: TN_HOLD,  ty: TN_HOLD,  tz: TN_LOAD};
            OP_LOAD:  w = '{tx: TN_LOAD,  ty: TN_HOLD,  tz: TN_HOLD};
            default:  w = CMD_IDLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small opcode FIFO with first-word fall-through read; pointers carry one
// extra wrap bit so full and empty are distinguishable.
`timescale 1ns/1ps
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Clocked control sequencer: buffers opcodes, issues one command cycle per
// instruction, then holds the datapath SETTLE cycles; keeps a sticky overflow.
`timescale 1ns/1ps
module instr_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [2:0] instr,
    output logic       instr_ready,
    input  logic       ovf_in,
    output logic [1:0] tx,
    output logic [1:0] ty,
    output logic [1:0] tz,
    output logic       tula,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       ovf_flag
);
    localparam int CW = $clog2(SETTLE) + 1;

    logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [2:0] fifo_dout;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cmd_word_t     cmd_q, cmd_d;
    logic          tula_q, tula_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          ill_q, ill_d;

    assign fifo_push = instr_valid && !fifo_full;

    instr_fifo #(.DEPTH(DEPTH), .WIDTH(3)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (instr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        cmd_d    = CMD_IDLE;
        tula_d   = tula_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_dout;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_legal(op_q)) begin
                    // command word and tula are registered so they appear in the EXEC cycle
                    state_d = ST_EXEC;
                    cmd_d   = op_cmd(op_q);
                    if (op_q == OP_ADD)   tula_d = 1'b0;
                    if (op_q == OP_SUB)   tula_d = 1'b1;
                    if (op_q == OP_CLRLD) ovf_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ill_d   = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT;
                cnt_d   = CW'(SETTLE - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (op_q == OP_ADD || op_q == OP_SUB) ovf_d = ovf_q | ovf_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            cmd_q   <= CMD_IDLE;
            tula_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            tula_q  <= tula_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign instr_ready = !fifo_full;
    assign tx          = cmd_q.tx;
    assign ty          = cmd_q.ty;
    assign tz          = cmd_q.tz;
    assign tula        = tula_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign done        = done_q;
    assign illegal     = ill_q;
    assign ovf_flag    = ovf_q;

endmodule
